stopwatch_ctrl: RTL

Sequencing controller for the stopwatch 16-bit count datapath, which is the bank of per-bit add/sub result selectors plus the count register. Converts raw start/clear/direction/mode buttons into the datapath controls: Op (up/down), M (mode), Clr (preset load) and a one-cycle Step enable every TICK_DIV clocks. Watches the datapath limit flags and stops counting at the terminal value.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/btn_sync_edge.sv | 38 +++
 rtl/stopwatch_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
//   sw_state_t : controller state encoding
//   OP_ADD     : datapath operation select for counting up
//   OP_SUB     : datapath operation select for counting down
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } sw_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse per bit.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset, clears all flops
//   din  : raw asynchronous inputs
//   sync : synchronised level (second flop)
//   rise : one-cycle pulse when the synchronised level goes 0 -> 1
module btn_sync_edge #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] sync,
    output logic [Width-1:0] rise
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;
    logic [Width-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    // Combinational pulse so the FSM acts on the edge following synchronisation.
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Sequencing controller for the stopwatch count datapath. Turns start/clear/
// direction/mode buttons into datapath controls and paces counting with a
// prescaler that issues one Step every TICK_DIV clocks (TICK_DIV >= 2).
// Ports:
//   CLK, RST  : clock (rising edge), asynchronous active-high reset
//   BtnStart  : level; each rising edge toggles run/pause
//   BtnClear  : level; rising edge returns to IDLE and presets the datapath
//   BtnDir    : level; 0 = count up, 1 = count down (sampled in IDLE only)
//   ModeSel   : level; datapath mode (sampled in IDLE only)
//   AtMax     : datapath flag, count at upper limit
//   AtZero    : datapath flag, count at lower limit
//   Op        : datapath operation, 0 = add, 1 = subtract
//   M         : datapath mode select
//   Clr       : datapath preset strobe
//   Step      : one-cycle count-register enable
//   Running   : high in RUN
//   Done      : high in DONE
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic CLK,
    input  logic RST,
    input  logic BtnStart,
    input  logic BtnClear,
    input  logic BtnDir,
    input  logic ModeSel,
    input  logic AtMax,
    input  logic AtZero,
    output logic Op,
    output logic M,
    output logic Clr,
    output logic Step,
    output logic Running,
    output logic Done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Bit order: {ModeSel, BtnDir, BtnClear, BtnStart}
    logic [3:0] btn_sync;
    logic [3:0] btn_rise;

    btn_sync_edge #(
        .Width(4)
    ) u_btn_sync (
        .clk  (CLK),
        .rst  (RST),
        .din  ({ModeSel, BtnDir, BtnClear, BtnStart}),
        .sync (btn_sync),
        .rise (btn_rise)
    );

    logic start_rise;
    logic clear_rise;
    logic dir_sync;
    logic mode_sync;
    logic unused_sync_bits;

    assign start_rise       = btn_rise[0];
    assign clear_rise       = btn_rise[1];
    assign dir_sync         = btn_sync[2];
    assign mode_sync        = btn_sync[3];
    assign unused_sync_bits = ^{btn_rise[3:2], btn_sync[1:0]};

    sw_state_t   state_q;
    logic [PW-1:0] presc_q;
    logic        op_q;
    logic        m_q;
    logic        clr_q;
    logic        step_q;

    logic tick;
    logic terminal;

    assign tick     = (presc_q == TICK_LAST);
    // Only the flag matching the frozen direction ends the run.
    assign terminal = (op_q == OP_SUB) ? AtZero : AtMax;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            presc_q <= '0;
            op_q    <= OP_ADD;
            m_q     <= 1'b0;
            clr_q   <= 1'b1;
            step_q  <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            step_q <= 1'b0;
            if (clear_rise) begin
                // Clear has priority over a simultaneous start edge.
                state_q <= IDLE;
                presc_q <= '0;
                clr_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        op_q <= dir_sync;
                        m_q  <= mode_sync;
                        if (start_rise) begin
                            state_q <= RUN;
                            presc_q <= '0;
                        end
                    end
                    RUN: begin
                        presc_q <= tick ? '0 : presc_q + PW'(1);
                        if (tick && terminal) begin
                            state_q <= DONE;
                        end else begin
                            // A tick's Step survives a pause on the same cycle.
                            if (tick) begin
                                step_q <= 1'b1;
                            end
                            if (start_rise) begin
                                state_q <= PAUSE;
                            end
                        end
                    end
                    PAUSE: begin
                        if (start_rise) begin
                            state_q <= RUN;
                        end
                    end
                    DONE: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign Op      = op_q;
    assign M       = m_q;
    assign Clr     = clr_q;
    assign Step    = step_q;
    assign Running = (state_q == RUN);
    assign Done    = (state_q == DONE);

endmodule
